// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - round-robin arbiter and sequencer sharing one booth_mult_16bit
//
// Optional feature macro: MULT_ARB_TIMEOUT_EN (abort WAIT after TIMEOUT cycles without mult_done)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req[NREQ]                per-requester request level
//   req_a, req_b[16*NREQ]    packed signed operands, requester i at [16i+15:16i]
//   gnt[NREQ]                one-hot, one-cycle pulse when operands are captured
//   rsp_valid/rsp_ready      response handshake
//   rsp_id, rsp_prod         owner index and signed 32-bit product
//   rsp_err                  timeout abort flag (0 when the timeout feature is off)
//   busy                     high in every state except IDLE
//   mult_start, mult_a/b     start pulse and operands to the multiplier
//   mult_p, mult_done        product and completion flag from the multiplier
module booth_mult_arbiter #(
   parameter int NREQ    = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      gnt,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [31:0]          rsp_prod,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 mult_start,
   output logic [15:0]          mult_a,
   output logic [15:0]          mult_b,
   input  logic [31:0]          mult_p,
   input  logic                 mult_done
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_RESP} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   ptr, id_q, win;
   logic              any_req, take, tmo_hit;
   logic [15:0]       op_a, op_b;
   logic [31:0]       prod_q;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              start_q, start_d, busy_q, busy_d, valid_q, valid_d;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]  wait_cnt;
   logic              err_q;
   // Fires in the TIMEOUT-th WAIT cycle; wait_cnt is 0 in the first one.
   assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   assign any_req = |req;
   assign take    = (state == S_IDLE) && any_req;

   // Round-robin pick: scan downward so the lowest offset from ptr is written last and wins.
   always_comb begin
      int idx;
      idx = 0;
      win = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx[ID_W-1:0]]) win = idx[ID_W-1:0];
      end
   end

   // Next-state logic. ARM exists only to let a stale mult_done from the previous
   // operation fall away before WAIT starts looking at it.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (any_req) state_nxt = S_START;
         S_START: state_nxt = S_ARM;
         S_ARM:   state_nxt = S_WAIT;
         S_WAIT:  if (mult_done || tmo_hit) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: computes the values the output registers take at the next edge,
   // so every port is driven straight from a flop.
   always_comb begin
      gnt_d   = '0;
      start_d = 1'b0;
      if (take) begin
         gnt_d[win] = 1'b1;
         start_d    = 1'b1;
      end
      busy_d  = (state_nxt != S_IDLE);
      valid_d = (state_nxt == S_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         ptr     <= '0;
         id_q    <= '0;
         op_a    <= '0;
         op_b    <= '0;
         prod_q  <= '0;
         gnt_q   <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         gnt_q   <= gnt_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         if (take) begin
            id_q <= win;
            op_a <= req_a[16*win +: 16];
            op_b <= req_b[16*win +: 16];
            ptr  <= (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
         end
         // A done on the timeout edge still wins and completes normally.
         if (state == S_WAIT) begin
            if (mult_done)    prod_q <= mult_p;
            else if (tmo_hit) prod_q <= '0;
         end
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == S_ARM)       wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
         if (state == S_WAIT && !mult_done && tmo_hit) err_q <= 1'b1;
         else if (state == S_RESP && rsp_ready)        err_q <= 1'b0;
      end
   end
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign gnt        = gnt_q;
   assign mult_start = start_q;
   assign busy       = busy_q;
   assign rsp_valid  = valid_q;
   assign rsp_id     = id_q;
   assign rsp_prod   = prod_q;
   assign mult_a     = op_a;
   assign mult_b     = op_b;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - self-checking bench for booth_mult_arbiter
module tb_booth_mult_arbiter;
   localparam int NREQ  = 4;
   localparam int ID_W  = 2;
   localparam int TMO   = 8;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     prod;
      logic            err;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [NREQ-1:0]     req;
   logic [16*NREQ-1:0]  req_a, req_b;
   logic [NREQ-1:0]     gnt;
   logic                rsp_valid, rsp_ready, rsp_err, busy, mult_start, mult_done;
   logic [ID_W-1:0]     rsp_id;
   logic [31:0]         rsp_prod, mult_p;
   logic [15:0]         mult_a, mult_b;

   booth_mult_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
      .rsp_err(rsp_err), .busy(busy), .mult_start(mult_start), .mult_a(mult_a),
      .mult_b(mult_b), .mult_p(mult_p), .mult_done(mult_done)
   );

   // Multiplier stand-in: done rises lat cycles after start and stays high until the next start.
   int          lat = 3;
   bit          hang = 1'b0, stale_force = 1'b0;
   int          m_cnt = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_p = '0;
   always @(posedge clk) begin
      if (mult_start) begin
         m_p    <= 32'($signed(mult_a)) * 32'($signed(mult_b));
         m_cnt  <= lat;
         m_done <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1 && !hang) m_done <= 1'b1;
      end
   end
   assign mult_done = m_done | stale_force;
   assign mult_p    = stale_force ? 32'hDEAD_BEEF : m_p;

   // Requester stand-ins and observation logs
   int   op_a [NREQ][DEPTH];
   int   op_b [NREQ][DEPTH];
   int   head [NREQ];
   int   tail [NREQ];
   bit   rdy_rand = 1'b0, rdy_fixed = 1'b1;
   logic [NREQ-1:0] gnt_raw [$];
   rsp_t rsp_log [$];
   int   start_cnt = 0;
   int   exp_id [$];
   int   exp_prod [$];
   int   m_ptr = 0;
   int   n_checks = 0, n_pass = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != '0) begin
            gnt_raw.push_back(gnt);
            for (int i = 0; i < NREQ; i++)
               if (gnt[i] && head[i] < tail[i]) head[i] = head[i] + 1;
         end
         if (mult_start) start_cnt = start_cnt + 1;
         if (rsp_valid && rsp_ready) begin
            rsp_t r;
            r.id = rsp_id; r.prod = rsp_prod; r.err = rsp_err;
            rsp_log.push_back(r);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
         req[i] = (head[i] < tail[i]);
         req_a[16*i +: 16] = 16'(op_a[i][head[i] % DEPTH]);
         req_b[16*i +: 16] = 16'(op_b[i][head[i] % DEPTH]);
      end
      rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
   endtask

   function automatic int rnd16();
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 7) == 0) v = 16'h8000;
      return int'($signed(v));
   endfunction

   task automatic enqueue(input int i, input int a, input int b);
      op_a[i][tail[i] % DEPTH] = a;
      op_b[i][tail[i] % DEPTH] = b;
      tail[i] = tail[i] + 1;
   endtask

   task automatic clear_logs();
      gnt_raw.delete();
      rsp_log.delete();
      start_cnt = 0;
   endtask

   // Reference: replay round-robin over everything pending, plain integer products.
   task automatic build_expect();
      int h [NREQ];
      int w, j;
      exp_id.delete();
      exp_prod.delete();
      for (int i = 0; i < NREQ; i++) h[i] = head[i];
      for (int n = 0; n < NREQ * DEPTH; n++) begin
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (w < 0 && h[j] < tail[j]) w = j;
         end
         if (w < 0) break;
         exp_id.push_back(w);
         exp_prod.push_back(op_a[w][h[w] % DEPTH] * op_b[w][h[w] % DEPTH]);
         h[w] = h[w] + 1;
         m_ptr = (w + 1) % NREQ;
      end
   endtask

   task automatic drain(input int n, input int budget, output bit to);
      int c;
      c = 0;
      while (rsp_log.size() < n && c < budget) begin
         tick();
         c++;
      end
      to = (rsp_log.size() < n);
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
      rdy_rand = 1'b0; rdy_fixed = 1'b1; hang = 1'b0; stale_force = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      m_ptr = 0;
      clear_logs();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0", gnt); else n_pass++;
      n_checks++; if ({rsp_valid, rsp_err, busy, mult_start} !== 4'b0)
         $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_err, busy, mult_start}); else n_pass++;
      n_checks++; if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", rsp_id); else n_pass++;
      n_checks++; if (rsp_prod !== 32'd0) $display("FAIL reset_prod: got %h want 0", rsp_prod); else n_pass++;
      n_checks++; if ({mult_a, mult_b} !== 32'd0) $display("FAIL reset_ops: got %h want 0", {mult_a, mult_b}); else n_pass++;
   endtask

   task automatic test_single();
      int t_valid;
      do_reset();
      lat = 3;
      enqueue(0, 3, 2);
      t_valid = -1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (t == 2) begin
            n_checks++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else n_pass++;
            n_checks++; if (mult_start !== 1'b1) $display("FAIL single_start: got %b want 1", mult_start); else n_pass++;
            n_checks++; if ({mult_a, mult_b} !== {16'd3, 16'd2}) $display("FAIL single_ops: got %h want 00030002", {mult_a, mult_b}); else n_pass++;
         end
         if (t == 3) begin
            n_checks++; if ({gnt, mult_start} !== 5'b0) $display("FAIL single_pulse: got %b want 0", {gnt, mult_start}); else n_pass++;
         end
         if (t == lat + 5) begin
            n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_idle: got %b want 00", {rsp_valid, busy}); else n_pass++;
         end
         if (rsp_valid && t_valid < 0) t_valid = t;
      end
      n_checks++; if (t_valid !== lat + 4) $display("FAIL single_latency: got %0d want %0d", t_valid, lat + 4); else n_pass++;
      n_checks++; if (start_cnt !== 1) $display("FAIL single_start_cnt: got %0d want 1", start_cnt); else n_pass++;
      n_checks++; if (rsp_log.size() !== 1) $display("FAIL single_rsp_cnt: got %0d want 1", rsp_log.size()); else n_pass++;
      if (rsp_log.size() > 0) begin
         n_checks++; if (rsp_log[0] !== {2'd0, 32'd6, 1'b0})
            $display("FAIL single_rsp: got id %0d prod %0d err %b want 0 6 0", rsp_log[0].id, $signed(rsp_log[0].prod), rsp_log[0].err); else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] want_g [5];
      int want_p [4];
      bit to;
      want_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      want_p = '{-40, 25, -1073709056, 0};
      do_reset();
      lat = $urandom_range(1, 4);
      enqueue(0, 10, -4); enqueue(1, -5, -5); enqueue(2, 32767, -32768); enqueue(3, 20, 0);
      enqueue(0, rnd16(), rnd16());
      build_expect();
      drain(5, 300, to);
      n_checks++; if (to !== 1'b0) $display("FAIL rr_timeout: got %0d responses want 5", rsp_log.size()); else n_pass++;
      n_checks++; if (gnt_raw.size() !== 5) $display("FAIL rr_gnt_cnt: got %0d want 5", gnt_raw.size()); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         if (k < gnt_raw.size()) begin
            n_checks++; if (gnt_raw[k] !== want_g[k]) $display("FAIL rr_gnt%0d: got %b want %b", k, gnt_raw[k], want_g[k]); else n_pass++;
         end
         if (k < rsp_log.size()) begin
            n_checks++; if (rsp_log[k].id !== ID_W'(exp_id[k])) $display("FAIL rr_id%0d: got %0d want %0d", k, rsp_log[k].id, exp_id[k]); else n_pass++;
            n_checks++; if (rsp_log[k].prod !== 32'(k < 4 ? want_p[k] : exp_prod[k]))
               $display("FAIL rr_prod%0d: got %0d want %0d", k, $signed(rsp_log[k].prod), k < 4 ? want_p[k] : exp_prod[k]); else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      int c;
      bit to;
      do_reset();
      lat = 2;
      rdy_fixed = 1'b0;
      enqueue(1, rnd16(), rnd16());
      enqueue(2, rnd16(), rnd16());
      build_expect();
      c = 0;
      while (!rsp_valid && c < 50) begin tick(); c++; end
      n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_seen: got %b want 1", rsp_valid); else n_pass++;
      for (int t = 0; t < 5; t++) begin
         tick();
         n_checks++; if ({rsp_valid, rsp_id} !== {1'b1, ID_W'(exp_id[0])})
            $display("FAIL bp_hold_id%0d: got %b/%0d want 1/%0d", t, rsp_valid, rsp_id, exp_id[0]); else n_pass++;
         n_checks++; if (rsp_prod !== 32'(exp_prod[0])) $display("FAIL bp_hold_prod%0d: got %0d want %0d", t, $signed(rsp_prod), exp_prod[0]); else n_pass++;
         n_checks++; if ({gnt, mult_start} !== 5'b0) $display("FAIL bp_no_start%0d: got %b want 0", t, {gnt, mult_start}); else n_pass++;
      end
      rdy_fixed = 1'b1;
      drain(2, 100, to);
      n_checks++; if (rsp_log.size() !== 2) $display("FAIL bp_rsp_cnt: got %0d want 2", rsp_log.size()); else n_pass++;
      for (int k = 0; k < rsp_log.size() && k < 2; k++) begin
         n_checks++; if (rsp_log[k] !== {ID_W'(exp_id[k]), 32'(exp_prod[k]), 1'b0})
            $display("FAIL bp_rsp%0d: got id %0d prod %0d want %0d %0d", k, rsp_log[k].id, $signed(rsp_log[k].prod), exp_id[k], exp_prod[k]); else n_pass++;
      end
   endtask

   task automatic test_stale_done();
      bit to;
      do_reset();
      lat = 2;
      enqueue(0, rnd16(), rnd16());
      build_expect();
      drain(1, 100, to);
      clear_logs();
      lat = 3;
      enqueue(3, rnd16(), rnd16());
      build_expect();
      stale_force = 1'b1;
      tick(); tick(); tick(); tick();
      stale_force = 1'b0;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL stale_early: got %b want 0", rsp_valid); else n_pass++;
      drain(1, 100, to);
      n_checks++; if (rsp_log.size() !== 1) $display("FAIL stale_rsp_cnt: got %0d want 1", rsp_log.size()); else n_pass++;
      if (rsp_log.size() > 0) begin
         n_checks++; if (rsp_log[0] !== {2'd3, 32'(exp_prod[0]), 1'b0})
            $display("FAIL stale_rsp: got id %0d prod %h want 3 %h", rsp_log[0].id, rsp_log[0].prod, 32'(exp_prod[0])); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      do_reset();
      lat = 30;
      enqueue(1, 1234, -77);
      tick(); tick(); tick(); tick();
      n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy); else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++; if ({gnt, rsp_valid, rsp_err, busy, mult_start} !== 8'b0)
         $display("FAIL midrst_flags: got %b want 0", {gnt, rsp_valid, rsp_err, busy, mult_start}); else n_pass++;
      n_checks++; if ({rsp_id, rsp_prod, mult_a, mult_b} !== '0)
         $display("FAIL midrst_data: got %h want 0", {rsp_id, rsp_prod, mult_a, mult_b}); else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
      m_ptr = 0;
      clear_logs();
      lat = 2;
      enqueue(2, rnd16(), rnd16());
      build_expect();
      drain(1, 100, to);
      n_checks++; if (gnt_raw.size() < 1 || gnt_raw[0] !== 4'b0100) $display("FAIL midrst_gnt: got %b want 0100", gnt_raw.size() > 0 ? gnt_raw[0] : 4'b0); else n_pass++;
      n_checks++; if (rsp_log.size() < 1 || rsp_log[0] !== {2'd2, 32'(exp_prod[0]), 1'b0}) $display("FAIL midrst_rsp: got %0d responses want id 2 prod %0d", rsp_log.size(), exp_prod[0]); else n_pass++;
      // ptr now points past requester 2; a reset must bring it back to 0.
      do_reset();
      enqueue(1, rnd16(), rnd16());
      enqueue(3, rnd16(), rnd16());
      build_expect();
      drain(2, 100, to);
      n_checks++; if (gnt_raw.size() < 2 || gnt_raw[0] !== 4'b0010 || gnt_raw[1] !== 4'b1000)
         $display("FAIL ptr_reset: got %0d grants first %b want 0010 then 1000", gnt_raw.size(), gnt_raw.size() > 0 ? gnt_raw[0] : 4'b0); else n_pass++;
   endtask

`ifdef MULT_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int t_valid;
      bit to;
      do_reset();
      hang = 1'b1;
      lat = 2;
      enqueue(0, 7, 9);
      build_expect();
      t_valid = -1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (rsp_valid && t_valid < 0) begin
            t_valid = t;
            n_checks++; if ({rsp_err, rsp_prod, rsp_id} !== {1'b1, 32'd0, 2'd0})
               $display("FAIL tmo_rsp: got err %b prod %h id %0d want 1 0 0", rsp_err, rsp_prod, rsp_id); else n_pass++;
         end
      end
      n_checks++; if (t_valid !== TMO + 4) $display("FAIL tmo_latency: got %0d want %0d", t_valid, TMO + 4); else n_pass++;
      n_checks++; if (rsp_err !== 1'b0) $display("FAIL tmo_err_clear: got %b want 0", rsp_err); else n_pass++;
      hang = 1'b0;
      lat = TMO;
      clear_logs();
      enqueue(2, -300, 41);
      build_expect();
      drain(1, 100, to);
      n_checks++; if (rsp_log.size() < 1 || rsp_log[0] !== {2'd2, 32'(-12300), 1'b0})
         $display("FAIL tmo_same_edge: got %0d responses want id 2 prod -12300 err 0", rsp_log.size()); else n_pass++;
   endtask
`endif

   task automatic test_random();
      int n;
      bit to;
      for (int r = 0; r < 6; r++) begin
         clear_logs();
         lat = $urandom_range(1, 6);
         rdy_rand = 1'b1;
         n = 0;
         for (int i = 0; i < NREQ; i++) begin
            int cnt;
            cnt = $urandom_range(0, 2);
            for (int j = 0; j < cnt; j++) enqueue(i, rnd16(), rnd16());
            n += cnt;
         end
         if (n == 0) enqueue(int'($urandom_range(0, NREQ - 1)), rnd16(), rnd16());
         build_expect();
         drain(exp_id.size(), 600, to);
         n_checks++; if (rsp_log.size() !== exp_id.size() || gnt_raw.size() !== exp_id.size())
            $display("FAIL rand%0d_cnt: got %0d rsp %0d gnt want %0d", r, rsp_log.size(), gnt_raw.size(), exp_id.size()); else n_pass++;
         for (int k = 0; k < exp_id.size() && k < rsp_log.size() && k < gnt_raw.size(); k++) begin
            n_checks++; if (gnt_raw[k] !== NREQ'(1) << exp_id[k]) $display("FAIL rand%0d_gnt%0d: got %b want %0d", r, k, gnt_raw[k], exp_id[k]); else n_pass++;
            n_checks++; if (rsp_log[k] !== {ID_W'(exp_id[k]), 32'(exp_prod[k]), 1'b0})
               $display("FAIL rand%0d_rsp%0d: got id %0d prod %0d want %0d %0d", r, k, rsp_log[k].id, $signed(rsp_log[k].prod), exp_id[k], exp_prod[k]); else n_pass++;
         end
      end
      rdy_rand = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_stale_done();
      test_reset_mid();
`ifdef MULT_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin arbiter and sequencer that shares a single `booth_mult_16bit` multiplier among `NREQ` requesters. It captures one requester's signed 16-bit operands and pulses the multiplier's `start`. It waits for `done` and returns the signed 32-bit product, tagged with the requester index, over a valid/ready response port. It sits between the multiplier and the client blocks that would otherwise each need their own multiplier.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of the requester index; must equal clog2(`NREQ`).
- `TIMEOUT`, default 200: maximum number of WAIT cycles before an abort. Used only with `MULT_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `req_a`  in  16*NREQ  packed signed multiplicands; requester i uses bits [16i+15:16i].
- `req_b`  in  16*NREQ  packed signed multipliers, packed the same way.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: the requester's operands have been captured.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester that owns the result.
- `rsp_prod`  out  32  signed product.
- `rsp_err`  out  1  timeout abort flag; constant 0 without `MULT_ARB_TIMEOUT_EN`.
- `busy`  out  1  high in every state except IDLE.
- `mult_start`  out  1  start pulse to the multiplier.
- `mult_a`, `mult_b`  out  16 each  operands to the multiplier.
- `mult_p`  in  32  multiplier product.
- `mult_done`  in  1  multiplier completion flag.

## Operation
- **State machine:** IDLE → START → ARM → WAIT → RESP → IDLE.
- **IDLE:** if any `req` bit is set, pick the winner `w` by round-robin, starting the search at pointer `ptr` and going upward with wrap.
  - Capture `req_a[w]` and `req_b[w]` into the operand registers and `w` into the id register.
  - Set `ptr` ← (`w`+1) mod NREQ.
  - Next state is START.
  - If no `req` bit is set, stay in IDLE.
- **START:** `mult_start`=1 and `gnt[w]`=1, both for exactly this cycle. Go to ARM.
- **ARM:** `mult_done` is ignored in this cycle, so a stale `done` left from the previous operation cannot complete the new one. Go to WAIT.
- **WAIT:** on `mult_done`=1, latch `mult_p` into `rsp_prod` and go to RESP.
- **RESP:** `rsp_valid`=1. `rsp_id`, `rsp_prod` and `rsp_err` are held stable until a cycle in which `rsp_ready`=1; the next state is then IDLE.
- `mult_a` and `mult_b` come from the operand registers and stay stable from START until leaving WAIT.
- Requester obligations:
  - Hold `req` and the operands stable until `gnt` is seen.
  - Deassert `req` no later than the cycle after `gnt` unless it wants another operation.
  - `req` is sampled only in IDLE, so there is no double grant.
- Arithmetic: the product is passed through unmodified, with no rounding or saturation. For example, -32768 × -32768 = 0x4000_0000.
- A requester that drops `req` before being granted is never granted; there is no residual state for it.
- **Reset** (any state, including mid-operation):
  - State goes to IDLE and `ptr` to 0.
  - `gnt`, `rsp_valid`, `rsp_err`, `busy` and `mult_start` go to 0.
  - `rsp_id`, `rsp_prod`, `mult_a` and `mult_b` go to 0.
  - The multiplier is not reset by this block.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `req` sampled in IDLE at edge E0 → START (`mult_start`, `gnt`) in the cycle after E0, ARM one cycle later, then WAIT.
- `mult_done` sampled in WAIT at edge Ek → `rsp_valid` high in the cycle after Ek.
- The earliest re-arbitration is the edge after `rsp_valid`&&`rsp_ready`.
- Minimum IDLE-to-IDLE time is 4 cycles plus the multiplier latency.
- `rsp_ready` already high when RESP is entered: RESP lasts exactly one cycle.
- Simultaneous requests: the lowest index at or above `ptr` wins. `ptr` wraps from NREQ-1 to 0.

## Configuration
- **`MULT_ARB_TIMEOUT_EN` defined:**
  - A cycle counter counts in WAIT and clears on entering WAIT.
  - If `TIMEOUT` cycles pass without `mult_done`, the block goes to RESP with `rsp_err`=1 and `rsp_prod`=0.
  - `rsp_err` clears on leaving RESP.
  - A `mult_done` on the same edge as the timeout completes normally, with `rsp_err`=0.
- **`MULT_ARB_TIMEOUT_EN` undefined:** no counter; WAIT lasts indefinitely and `rsp_err` is tied to 0.

## Test plan
- Reset, then requester 0 requests 3 × 2 with `rsp_ready`=1 → `gnt`=0001 pulse, one `mult_start` pulse, then `rsp_valid` with `rsp_id`=0 and `rsp_prod`=6; `busy` returns to 0.
- All four requesters request continuously (10×-4, -5×-5, 32767×-32768, 20×0) → grants in order 0,1,2,3,0. Products are -40, 25, -1073709056 and 0, each with the matching `rsp_id`.
- `rsp_ready` held low for 5 cycles during RESP → `rsp_valid`, `rsp_id` and `rsp_prod` stay stable for all 5 cycles; there is no new `mult_start` and no `gnt`.
- Stale `mult_done` held high from the previous operation through START/ARM → no early completion; the result equals the new operands' product.
- `rst` asserted during WAIT → next cycle is IDLE with all outputs 0 and `ptr`=0. A subsequent request from requester 2 is granted first with `gnt`=0100.
- With `MULT_ARB_TIMEOUT_EN` and `TIMEOUT`=8, `mult_done` held low → RESP after 8 WAIT cycles with `rsp_err`=1 and `rsp_prod`=0.
